// File: rtl/load_hazard_scoreboard.sv
// Load-use hazard scoreboard: one pending bit per register for in-flight loads.
// Drives PC/IF-ID write enables, ID/EX bubble, stall counter and sticky error.
module load_hazard_scoreboard #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [AW-1:0]    rs1_addr_i,
  input  logic [AW-1:0]    rs2_addr_i,
  input  logic             rs1_used_i,
  input  logic             rs2_used_i,
  input  logic             issue_valid_i,
  input  logic [AW-1:0]    issue_rd_i,
  input  logic             issue_load_i,
  input  logic             flush_i,
  input  logic             mem_busy_i,
  input  logic             ld_done_i,
  input  logic [AW-1:0]    ld_rd_i,
  output logic             hazard_stall_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             idex_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [NREG-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic rs1_haz, rs2_haz;
  logic issue_eff, ld_ok;

  // A load returning this cycle lands in MEM/WB at the edge, so WB
  // forwarding covers the consumer: no stall needed.
  assign rs1_haz = rs1_used_i && (rs1_addr_i != '0)
                && pend_q[rs1_addr_i]
                && !(ld_done_i && (ld_rd_i == rs1_addr_i));
  assign rs2_haz = rs2_used_i && (rs2_addr_i != '0)
                && pend_q[rs2_addr_i]
                && !(ld_done_i && (ld_rd_i == rs2_addr_i));

  assign hazard_stall_o = rs1_haz || rs2_haz;
  assign pc_write_o     = !(hazard_stall_o || mem_busy_i);
  assign ifid_write_o   = !(hazard_stall_o || mem_busy_i);
  // Frozen pipeline holds ID/EX as-is instead of bubbling.
  assign idex_bubble_o  = hazard_stall_o && !mem_busy_i;

  assign issue_eff = issue_valid_i && !hazard_stall_o
                  && !mem_busy_i && !flush_i;
  assign ld_ok     = ld_done_i && !mem_busy_i;

  always_comb begin
    pend_d = pend_q;
    if (ld_ok)
      pend_d[ld_rd_i] = 1'b0;
    // Applied after the clear so a back-to-back load to the
    // same register keeps its bit.
    if (issue_eff && issue_load_i && (issue_rd_i != '0))
      pend_d[issue_rd_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (idex_bubble_o && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + CNT_ONE;
  end

  always_comb begin
    err_d = err_q;
    if (ld_ok && (ld_rd_i != '0) && !pend_q[ld_rd_i])
      err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign stall_cnt_o = cnt_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// Bench for load_hazard_scoreboard: directed per-cycle vectors feed an
// expectation queue; a negedge monitor pops and compares every output.
module tb_load_hazard_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1, rs2, ird, ldrd;
  logic        u1, u2, iv, il, fl, bsy, ld;
  logic        haz, pcw, ifw, bub, err;
  logic [15:0] cnt;

  typedef struct packed {
    logic        h;
    logic        p;
    logic        b;
    logic [15:0] c;
    logic        e;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 0;

  load_hazard_scoreboard #(.NREG(32), .AW(5), .CNT_W(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .rs1_addr_i    (rs1),
    .rs2_addr_i    (rs2),
    .rs1_used_i    (u1),
    .rs2_used_i    (u2),
    .issue_valid_i (iv),
    .issue_rd_i    (ird),
    .issue_load_i  (il),
    .flush_i       (fl),
    .mem_busy_i    (bsy),
    .ld_done_i     (ld),
    .ld_rd_i       (ldrd),
    .hazard_stall_o(haz),
    .pc_write_o    (pcw),
    .ifid_write_o  (ifw),
    .idex_bubble_o (bub),
    .stall_cnt_o   (cnt),
    .err_o         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // Monitor: one expectation per sampled cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      chk("hazard_stall", {15'd0, haz}, {15'd0, x.h});
      chk("pc_write",     {15'd0, pcw}, {15'd0, x.p});
      chk("ifid_write",   {15'd0, ifw}, {15'd0, x.p});
      chk("idex_bubble",  {15'd0, bub}, {15'd0, x.b});
      chk("stall_cnt",    cnt,          x.c);
      chk("err",          {15'd0, err}, {15'd0, x.e});
    end
  end

  task automatic push(logic h, logic p, logic b, logic [15:0] c, logic e);
    exp_t x;
    x.h = h; x.p = p; x.b = b; x.c = c; x.e = e;
    exp_q.push_back(x);
  endtask

  // Drive one ID-stage cycle shortly after the edge and queue its outputs.
  task automatic cyc(
    input logic [4:0] a1, input logic b1,
    input logic [4:0] a2, input logic b2,
    input logic v, input logic [4:0] rd, input logic lo,
    input logic f, input logic bz,
    input logic d, input logic [4:0] drd,
    input logic h, input logic p, input logic b,
    input logic [15:0] c, input logic e);
    @(posedge clk);
    #1;
    rs1 = a1; u1 = b1; rs2 = a2; u2 = b2;
    iv = v; ird = rd; il = lo; fl = f; bsy = bz;
    ld = d; ldrd = drd;
    push(h, p, b, c, e);
  endtask

  initial begin
    rst_n = 1'b0;
    rs1 = 0; rs2 = 0; ird = 0; ldrd = 0;
    u1 = 0; u2 = 0; iv = 0; il = 0; fl = 0; bsy = 0; ld = 0;

    // Reset state
    @(posedge clk); #1;
    push(0, 1, 0, 16'd0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // lw x5 ; add x6,x5,x1 -> single stall
    cyc(2,1, 0,0, 1,5,1, 0,0, 0,0,  0,1,0, 16'd0, 0);
    cyc(5,1, 1,1, 1,6,0, 0,0, 0,0,  1,0,1, 16'd0, 0);
    cyc(5,1, 1,1, 1,6,0, 0,0, 1,5,  0,1,0, 16'd1, 0);
    cyc(5,1, 0,0, 0,0,0, 0,0, 0,0,  0,1,0, 16'd1, 0);

    // lw x5 ; nop ; add x6,x5,x1 -> bypass, no stall
    cyc(2,1, 0,0, 1,5,1, 0,0, 0,0,  0,1,0, 16'd1, 0);
    cyc(0,0, 0,0, 1,0,0, 0,0, 0,0,  0,1,0, 16'd1, 0);
    cyc(5,1, 1,1, 1,6,0, 0,0, 1,5,  0,1,0, 16'd1, 0);
    cyc(5,1, 0,0, 0,0,0, 0,0, 0,0,  0,1,0, 16'd1, 0);

    // lw x0 ; add x1,x0,x0 ; x0 completion raises no error
    cyc(2,1, 0,0, 1,0,1, 0,0, 0,0,  0,1,0, 16'd1, 0);
    cyc(0,1, 0,1, 1,1,0, 0,0, 0,0,  0,1,0, 16'd1, 0);
    cyc(0,0, 0,0, 0,0,0, 0,0, 1,0,  0,1,0, 16'd1, 0);

    // lw x5 held by busy memory for 3 cycles
    cyc(2,1, 0,0, 1,5,1, 0,1, 0,0,  0,0,0, 16'd1, 0);
    cyc(2,1, 0,0, 1,5,1, 0,1, 0,0,  0,0,0, 16'd1, 0);
    cyc(2,1, 0,0, 1,5,1, 0,1, 0,0,  0,0,0, 16'd1, 0);
    cyc(2,1, 0,0, 1,5,1, 0,0, 0,0,  0,1,0, 16'd1, 0);
    // consumer frozen: stall seen but not counted, ld_done ignored
    cyc(5,1, 1,1, 1,6,0, 0,1, 1,7,  1,0,0, 16'd1, 0);
    cyc(5,1, 1,1, 1,6,0, 0,0, 0,0,  1,0,1, 16'd1, 0);
    cyc(5,1, 1,1, 1,6,0, 0,0, 1,5,  0,1,0, 16'd2, 0);
    cyc(0,0, 0,0, 0,0,0, 0,0, 0,0,  0,1,0, 16'd2, 0);

    // completion for non-pending x9 -> sticky error
    cyc(0,0, 0,0, 0,0,0, 0,0, 1,9,  0,1,0, 16'd2, 0);
    cyc(0,0, 0,0, 0,0,0, 0,0, 0,0,  0,1,0, 16'd2, 1);
    cyc(0,0, 0,0, 0,0,0, 0,0, 0,0,  0,1,0, 16'd2, 1);

    // flushed lw x5 must not mark x5
    cyc(2,1, 0,0, 1,5,1, 1,0, 0,0,  0,1,0, 16'd2, 1);
    cyc(5,1, 0,0, 1,6,0, 0,0, 0,0,  0,1,0, 16'd2, 1);

    // back-to-back lw x5: set beats same-cycle clear
    cyc(2,1, 0,0, 1,5,1, 0,0, 0,0,  0,1,0, 16'd2, 1);
    cyc(2,1, 0,0, 1,5,1, 0,0, 1,5,  0,1,0, 16'd2, 1);
    cyc(5,1, 0,0, 1,6,0, 0,0, 0,0,  1,0,1, 16'd2, 1);
    cyc(5,1, 0,0, 1,6,0, 0,0, 0,0,  1,0,1, 16'd3, 1);
    cyc(5,1, 0,0, 1,6,0, 0,0, 0,0,  1,0,1, 16'd4, 1);
    cyc(5,1, 0,0, 1,6,0, 0,0, 0,0,  1,0,1, 16'd5, 1);
    cyc(5,1, 0,0, 1,6,0, 0,0, 0,0,  1,0,1, 16'd6, 1);

    // async reset mid-run with x5 pending and count 7
    @(posedge clk); #1;
    rst_n = 1'b0;
    push(0, 1, 0, 16'd0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(0, 1, 0, 16'd0, 0);
    cyc(5,1, 0,0, 1,6,0, 0,0, 0,0,  0,1,0, 16'd0, 0);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    done = 1;
    $finish;
  end

  initial begin
    #20000;
    if (!done) begin
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
    end
  end

endmodule
